// File: rtl/matrix_scan_driver_pkg.sv
// Shared constants and types for the 5x7 LED matrix column scan driver.
// Column indices come from an upstream mod-5 counter; 5..7 mean "no column".
package matrix_scan_driver_pkg;

    localparam int NUM_COLS = 5;
    localparam int NUM_ROWS = 7;
    localparam int COL_W    = 3;

    localparam logic [COL_W-1:0]    COL_LAST = 3'd4;
    localparam logic [NUM_COLS-1:0] COL_OFF  = 5'b11111;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_e;

    function automatic logic col_valid(input logic [COL_W-1:0] col);
        return col <= COL_LAST;
    endfunction

endpackage

// File: rtl/matrix_scan_driver_scan_frame_buffer.sv
// Double-buffered 5x7 frame image: writes go to the back bank, the scan reads
// the front bank, and a swap flips which bank plays which role.
module scan_frame_buffer
    import matrix_scan_driver_pkg::*;
(
    input  logic                clock,
    input  logic                reset_n,
    input  logic                wr_en,
    input  logic [COL_W-1:0]    wr_col,
    input  logic [NUM_ROWS-1:0] wr_data,
    input  logic                swap,
    input  logic [COL_W-1:0]    rd_col,
    output logic [NUM_ROWS-1:0] front_data
);

    logic [NUM_ROWS-1:0] bank_q [2][NUM_COLS];
    logic                front_sel_q;

    // NOTE: the banks are only 70 flops, so they are reset like ordinary state
    // rather than left uninitialised as a RAM would be.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            front_sel_q <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int c = 0; c < NUM_COLS; c++) begin
                    bank_q[b][c] <= '0;
                end
            end
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values;
            // a write in the swap cycle therefore lands in the old back bank.
            if (wr_en && col_valid(wr_col)) begin
                bank_q[~front_sel_q][wr_col] <= wr_data;
            end
            if (swap) begin
                front_sel_q <= ~front_sel_q;
            end
        end
    end

    assign front_data = col_valid(rd_col) ? bank_q[front_sel_q][rd_col] : '0;

endmodule

// File: rtl/matrix_scan_driver.sv
// Column scan driver for a 5x7 LED matrix: blanks on every column change,
// then drives the active-low column enable and the front-buffer row pattern.
module matrix_scan_driver
    import matrix_scan_driver_pkg::*;
#(
    parameter int BLANK_CYCLES = 2
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [COL_W-1:0]    col_idx,
    input  logic                wr_en,
    input  logic [COL_W-1:0]    wr_col,
    input  logic [NUM_ROWS-1:0] wr_data,
    input  logic                swap_req,
    output logic                swap_ack,
    output logic [NUM_COLS-1:0] col_out,
    output logic [NUM_ROWS-1:0] row_out,
    output logic                frame_pulse
);

    localparam logic [3:0] CNT_LAST = 4'(BLANK_CYCLES - 1);

    logic [COL_W-1:0]    idx_q;
    scan_state_e         state_q;
    logic [3:0]          cnt_q;
    logic                run_q;
    logic                pending_q;
    logic                change;
    logic                boundary;
    logic                do_swap;
    logic [NUM_ROWS-1:0] front_data;

    assign change   = (col_idx != idx_q);
    assign boundary = (idx_q == COL_LAST) && (col_idx == '0);
    assign do_swap  = boundary && (pending_q || swap_req);

    // run_q holds the blank count still on the edge that samples reset release,
    // so the first drive comes BLANK_CYCLES+1 cycles after release.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            idx_q   <= '0;
            state_q <= BLANK;
            cnt_q   <= '0;
            run_q   <= 1'b0;
        end else begin
            idx_q <= col_idx;
            run_q <= 1'b1;
            if (change) begin
                state_q <= BLANK;
                cnt_q   <= '0;
            end else if (state_q == BLANK && run_q) begin
                if (cnt_q == CNT_LAST) begin
                    if (col_valid(idx_q)) begin
                        state_q <= DRIVE;
                    end
                end else begin
                    cnt_q <= cnt_q + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending_q   <= 1'b0;
            swap_ack    <= 1'b0;
            frame_pulse <= 1'b0;
        end else begin
            frame_pulse <= boundary;
            swap_ack    <= do_swap;
            if (do_swap) begin
                pending_q <= 1'b0;
            end else if (swap_req) begin
                pending_q <= 1'b1;
            end
        end
    end

    scan_frame_buffer u_frame_buffer (
        .clock      (clock),
        .reset_n    (reset_n),
        .wr_en      (wr_en),
        .wr_col     (wr_col),
        .wr_data    (wr_data),
        .swap       (do_swap),
        .rd_col     (idx_q),
        .front_data (front_data)
    );

    // NOTE: every output gets a default before the state test, so no latch is inferred.
    always_comb begin
        col_out = COL_OFF;
        row_out = '0;
        if (state_q == DRIVE) begin
            col_out = COL_OFF ^ (NUM_COLS'(1) << idx_q);
            row_out = front_data;
        end
    end

endmodule

// File: tb/tb_matrix_scan_driver.sv
// Scoreboard bench for matrix_scan_driver: a timing/arithmetic reference model
// predicts every cycle's outputs; a monitor compares them after each edge.
module tb_matrix_scan_driver;

    localparam int B = 2;

    typedef struct packed {
        logic       ack;
        logic       frame;
        logic [6:0] row;
        logic [4:0] col;
    } obs_t;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [2:0] col_idx;
    logic       wr_en;
    logic [2:0] wr_col;
    logic [6:0] wr_data;
    logic       swap_req;
    logic       swap_ack;
    logic [4:0] col_out;
    logic [6:0] row_out;
    logic       frame_pulse;

    matrix_scan_driver #(.BLANK_CYCLES(B)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .col_idx     (col_idx),
        .wr_en       (wr_en),
        .wr_col      (wr_col),
        .wr_data     (wr_data),
        .swap_req    (swap_req),
        .swap_ack    (swap_ack),
        .col_out     (col_out),
        .row_out     (row_out),
        .frame_pulse (frame_pulse)
    );

    always #5 clock = ~clock;

    int   checks = 0;
    int   errors = 0;
    obs_t exp_q[$];

    // Reference model: images as plain arrays swapped by value, and drive
    // decided from the time elapsed since the last column change.
    logic [6:0] m_front [5];
    logic [6:0] m_back  [5];
    logic [2:0] m_idx;
    logic       m_pending;
    int         cyc;
    int         last_change;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 5; c++) begin
            m_front[c] = '0;
            m_back[c]  = '0;
        end
        m_idx       = '0;
        m_pending   = 1'b0;
        cyc         = 0;
        last_change = 0;
    endtask

    task automatic model_step(input logic [2:0] ci, input logic we, input logic [2:0] wc,
                              input logic [6:0] wd, input logic sr);
        obs_t       e;
        logic [6:0] tmp [5];
        logic       bnd;
        logic       drive;
        bnd = (m_idx == 3'd4) && (ci == 3'd0);
        if (ci != m_idx) last_change = cyc;
        if (we && wc < 3'd5) m_back[wc] = wd;
        e.ack = 1'b0;
        if (bnd && (m_pending || sr)) begin
            tmp       = m_front;
            m_front   = m_back;
            m_back    = tmp;
            e.ack     = 1'b1;
            m_pending = 1'b0;
        end else if (sr) begin
            m_pending = 1'b1;
        end
        m_idx = ci;
        cyc++;
        drive   = (m_idx < 3'd5) && (cyc >= last_change + B + 1);
        e.col   = drive ? ~(5'b00001 << m_idx) : 5'b11111;
        e.row   = drive ? m_front[m_idx] : 7'h00;
        e.frame = bnd;
        exp_q.push_back(e);
    endtask

    // Inputs change 3 time units after a rising edge; the monitor samples at +1.
    task automatic step(input logic [2:0] ci, input logic we, input logic [2:0] wc,
                        input logic [6:0] wd, input logic sr);
        col_idx  = ci;
        wr_en    = we;
        wr_col   = wc;
        wr_data  = wd;
        swap_req = sr;
        model_step(ci, we, wc, wd, sr);
        @(posedge clock);
        #3;
    endtask

    task automatic idle(input logic [2:0] ci, input int n);
        for (int i = 0; i < n; i++) step(ci, 1'b0, 3'd0, 7'h00, 1'b0);
    endtask

    task automatic release_reset();
        reset_n = 1'b1;
        model_reset();
        #1;
        check("release col_out", 32'(col_out), 32'h1f);
    endtask

    initial begin : monitor
        obs_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check($sformatf("cycle %0d {ack,frame,row,col}", cyc),
                      32'({swap_ack, frame_pulse, row_out, col_out}), 32'(e));
            end
        end
    end

    initial begin : stimulus
        int cur;
        int hold;
        reset_n  = 1'b0;
        col_idx  = '0;
        wr_en    = 1'b0;
        wr_col   = '0;
        wr_data  = '0;
        swap_req = 1'b0;
        repeat (2) @(posedge clock);
        #3;
        check("reset col_out", 32'(col_out), 32'h1f);
        check("reset row_out", 32'(row_out), 32'h0);
        check("reset swap_ack", 32'(swap_ack), 32'h0);
        check("reset frame_pulse", 32'(frame_pulse), 32'h0);
        release_reset();

        // First drive after reset release.
        idle(3'd0, 5);

        // Write col 2, request swap, then scan a full frame into col 2.
        step(3'd0, 1'b1, 3'd2, 7'h55, 1'b1);
        for (int c = 1; c <= 7; c++) idle(3'((c % 5)), 4);

        // Write to col 3 is invisible until the next boundary plus swap.
        idle(3'd1, 4);
        step(3'd1, 1'b1, 3'd3, 7'h2a, 1'b0);
        idle(3'd3, 5);
        step(3'd4, 1'b0, 3'd0, 7'h00, 1'b1);
        idle(3'd4, 3);
        idle(3'd0, 4);
        idle(3'd1, 2);
        idle(3'd2, 2);
        idle(3'd3, 5);

        // Back-to-back changes restart the blank window.
        idle(3'd1, 4);
        idle(3'd2, 1);
        idle(3'd3, 5);

        // Invalid index held, then a valid column; no frame boundary.
        idle(3'd6, 10);
        idle(3'd0, 5);

        // Asynchronous reset while driving with a swap pending.
        idle(3'd1, 1);
        idle(3'd2, 4);
        step(3'd2, 1'b0, 3'd0, 7'h00, 1'b1);
        idle(3'd2, 2);
        reset_n = 1'b0;
        #1;
        check("async reset col_out", 32'(col_out), 32'h1f);
        check("async reset row_out", 32'(row_out), 32'h0);
        repeat (2) @(posedge clock);
        #3;
        release_reset();
        for (int c = 2; c <= 7; c++) idle(3'((c % 5)), 4);
        step(3'd3, 1'b1, 3'd7, 7'h7f, 1'b0);

        // Randomised scanning, writes and swap requests.
        cur  = 3;
        hold = 0;
        for (int n = 0; n < 400; n++) begin
            if (hold == 0) begin
                if ($urandom_range(0, 9) < 8) cur = (cur < 5) ? (cur + 1) % 5 : 0;
                else                         cur = int'($urandom_range(0, 7));
                hold = int'($urandom_range(1, 6));
            end
            hold--;
            step(3'(cur), ($urandom_range(0, 9) < 3), 3'($urandom_range(0, 7)),
                 7'($urandom), ($urandom_range(0, 9) == 0));
        end

        @(posedge clock);
        #3;
        check("scoreboard drained", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
